// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
`include "defines.v"

package regfile_mp_pkg;

  localparam int unsigned DefXlen = `XLEN;
  localparam int unsigned DefNreg = 1 << `REG_AW;

  // True when addr names the hardwired zero register.
  function automatic logic is_zero_reg(input logic [31:0] addr, input int unsigned zero_reg);
    return (zero_reg != 0) && (addr == '0);
  endfunction

endpackage

// File: rtl/defines.v
`ifndef REGFILE_DEFINES_V
`define REGFILE_DEFINES_V

// Machine word width shared by the integer datapath.
`define XLEN 32
// Architectural register address width (32 registers).
`define REG_AW 5

`endif

// File: rtl/regfile_bypass.sv
// One read port: selects register contents or forwards a same-cycle write-back.
module regfile_bypass #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic [AW-1:0]       rd_addr_i,
  input  logic [XLEN-1:0]     rf_data_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NWR-1:0]      wr_we_i,
  output logic [XLEN-1:0]     rd_data_o,
  output logic                wb_hit_o
);

  // Later ports overwrite earlier matches, so the highest index wins.
  always_comb begin
    rd_data_o = rf_data_i;
    wb_hit_o  = 1'b0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_we_i[j] && (wr_addr_i[j*AW +: AW] == rd_addr_i)) begin
        wb_hit_o  = 1'b1;
        rd_data_o = wr_data_i[j*XLEN +: XLEN];
      end
    end
    if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
      rd_data_o = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-write scoreboard for issue control.
`include "defines.v"

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN     = `XLEN,
  parameter int unsigned NREG     = DefNreg,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREG),
  localparam int unsigned CW      = $clog2(NREG + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rs_addr_i,
  output logic [NRD*XLEN-1:0] rs_data_o,
  output logic [NRD-1:0]      rs_busy_o,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [NWR-1:0]      wr_we_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_rd_i,
  output logic                iss_ready_o,
  input  logic                flush_i,
  output logic [CW-1:0]       pend_cnt_o
);

  logic [XLEN-1:0] x_q [NREG];
  logic [XLEN-1:0] x_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] wb_hit;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            iss_rd_zero;
  logic            iss_fire;

  logic [XLEN-1:0] byp_data [NRD];
  logic [NRD-1:0]  byp_hit;

  // Register-file next state: port order gives the highest index priority.
  always_comb begin
    x_d = x_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_we_i[j] && !is_zero_reg(32'(wr_addr_i[j*AW +: AW]), ZERO_REG)) begin
        x_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*XLEN +: XLEN];
      end
    end
  end

  // Registers targeted by any write-back this cycle.
  always_comb begin
    wb_hit = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wr_we_i[j]) begin
        wb_hit[wr_addr_i[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Issue handshake; a write-back landing this cycle frees the destination.
  always_comb begin
    iss_rd_zero = is_zero_reg(32'(iss_rd_i), ZERO_REG);
    iss_ready_o = rst_i | iss_rd_zero | ~pend_q[iss_rd_i] | wb_hit[iss_rd_i];
    iss_fire    = iss_valid_i & iss_ready_o & ~iss_rd_zero & ~rst_i;
  end

  // Scoreboard next state: clear on write-back, set on issue (set wins), flush beats both.
  always_comb begin
    pend_d = pend_q & ~wb_hit;
    if (iss_fire) begin
      pend_d[iss_rd_i] = 1'b1;
    end
    if (flush_i) begin
      pend_d = '0;
    end
    if (ZERO_REG != 0) begin
      pend_d[0] = 1'b0;
    end
    cnt_d = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + CW'(pend_d[r]);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        x_q[r] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      x_q    <= x_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt_o = cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_bypass #(
      .XLEN     (XLEN),
      .AW       (AW),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
    ) u_bypass (
      .rd_addr_i (rs_addr_i[k*AW +: AW]),
      .rf_data_i (x_q[rs_addr_i[k*AW +: AW]]),
      .wr_addr_i (wr_addr_i),
      .wr_data_i (wr_data_i),
      .wr_we_i   (wr_we_i),
      .rd_data_o (byp_data[k]),
      .wb_hit_o  (byp_hit[k])
    );
  end

  // Read outputs are forced quiet while reset is held.
  always_comb begin
    for (int unsigned k = 0; k < NRD; k++) begin
      rs_data_o[k*XLEN +: XLEN] = rst_i ? '0 : byp_data[k];
      rs_busy_o[k] = ~rst_i & pend_q[rs_addr_i[k*AW +: AW]] & ~byp_hit[k];
    end
  end

  // Backdoor read of the architectural state for simulation tooling.
  task automatic readRegister(input logic [AW-1:0] raddr, output logic [XLEN-1:0] rdata);
    rdata = x_q[raddr];
  endtask

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, async-reset sequence,
// then random traffic compared against a register/scoreboard reference model.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  wr_we;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        flush;
  logic [5:0]  pend_cnt;

  // Driven stimulus fields.
  logic        we0, we1, iv, fl;
  logic [4:0]  wa0, wa1, ird, ra0, ra1;
  logic [31:0] wd0, wd1;

  assign rs_addr   = {ra1, ra0};
  assign wr_addr   = {wa1, wa0};
  assign wr_data   = {wd1, wd0};
  assign wr_we     = {we1, we0};
  assign iss_valid = iv;
  assign iss_rd    = ird;
  assign flush     = fl;

  regfile_mp dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rs_addr_i   (rs_addr),
    .rs_data_o   (rs_data),
    .rs_busy_o   (rs_busy),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_we_i     (wr_we),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .iss_ready_o (iss_ready),
    .flush_i     (flush),
    .pend_cnt_o  (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mx [32];
  bit          mpend [32];

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mx[r] = '0;
      mpend[r] = 1'b0;
    end
  endtask

  function automatic bit m_wb(input logic [4:0] a);
    return (we0 && wa0 == a) || (we1 && wa1 == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] r;
    if (a == 0) return 32'h0;
    r = mx[a];
    if (we0 && wa0 == a) r = wd0;
    if (we1 && wa1 == a) r = wd1;
    return r;
  endfunction

  function automatic bit m_ready();
    return (ird == 0) || !mpend[ird] || m_wb(ird);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(mpend[r]);
    return c;
  endfunction

  // Applies one clock edge of architectural effects.
  task automatic model_update();
    bit fire;
    fire = iv && m_ready() && (ird != 0);
    for (int r = 0; r < 32; r++) if (m_wb(5'(r))) mpend[r] = 1'b0;
    if (we0 && wa0 != 0) mx[wa0] = wd0;
    if (we1 && wa1 != 0) mx[wa1] = wd1;
    if (fire) mpend[ird] = 1'b1;
    if (fl) for (int r = 0; r < 32; r++) mpend[r] = 1'b0;
    mpend[0] = 1'b0;
  endtask

  task automatic idle_inputs();
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    iv = 0; ird = 0; fl = 0; ra0 = 0; ra1 = 0;
  endtask

  // Compare combinational outputs with the model, take an edge, compare the count.
  task automatic model_cycle();
    #2;
    chk("rd0_data", rs_data[31:0], m_read(ra0));
    chk("rd1_data", rs_data[63:32], m_read(ra1));
    chk("rd0_busy", 32'(rs_busy[0]), 32'(mpend[ra0] && !m_wb(ra0)));
    chk("rd1_busy", 32'(rs_busy[1]), 32'(mpend[ra1] && !m_wb(ra1)));
    chk("iss_ready", 32'(iss_ready), 32'(m_ready()));
    @(posedge clk);
    model_update();
    #1;
    chk("pend_cnt", 32'(pend_cnt), 32'(m_count()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we0; logic [4:0] wa0; logic [31:0] wd0;
    logic        we1; logic [4:0] wa1; logic [31:0] wd1;
    logic        iv;  logic [4:0] ird; logic fl;
    logic [4:0]  ra0; logic [4:0] ra1;
    logic [31:0] e_d0; logic [31:0] e_d1;
    logic        e_b0; logic e_b1; logic e_rdy; int e_cnt;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(
    input logic w0, input logic [4:0] a0, input logic [31:0] d0,
    input logic w1, input logic [4:0] a1, input logic [31:0] d1,
    input logic v, input logic [4:0] rd, input logic f,
    input logic [4:0] r0, input logic [4:0] r1,
    input logic [31:0] ed0, input logic [31:0] ed1,
    input logic eb0, input logic eb1, input logic erdy, input int ecnt);
    vec_t t;
    t.we0 = w0; t.wa0 = a0; t.wd0 = d0; t.we1 = w1; t.wa1 = a1; t.wd1 = d1;
    t.iv = v; t.ird = rd; t.fl = f; t.ra0 = r0; t.ra1 = r1;
    t.e_d0 = ed0; t.e_d1 = ed1; t.e_b0 = eb0; t.e_b1 = eb1; t.e_rdy = erdy; t.e_cnt = ecnt;
    return t;
  endfunction

  initial begin
    //                 we0 wa0 wd0           we1 wa1 wd1           iv ird fl ra0 ra1 d0            d1            b0 b1 rdy cnt
    tbl.push_back(mk(1, 5, 32'h0000_1234, 1, 5, 32'h0000_BEEF, 0, 0, 0, 5, 0, 32'h0000_BEEF, 32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 5, 5, 32'h0000_BEEF, 32'h0000_BEEF, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 32'h0,         1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 5, 32'h0,        32'h0000_BEEF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 7, 0, 7, 0, 32'h0,        32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 7, 0, 7, 0, 32'h0,        32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,         1, 7, 32'h42,        0, 7, 0, 7, 0, 32'h42,       32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 7, 5, 32'h42,       32'h0000_BEEF, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(1, 3, 32'h33,        0, 0, 32'h0,         1, 3, 0, 3, 0, 32'h33,       32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 3, 0, 3, 0, 32'h33,       32'h0,        1, 0, 0, 1));
    tbl.push_back(mk(1, 3, 32'h34,        0, 0, 32'h0,         0, 0, 0, 3, 0, 32'h34,       32'h0,        0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 2, 0, 1, 0, 32'h0,        32'h0,        1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 3, 0, 2, 1, 32'h0,        32'h0,        1, 1, 1, 3));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 4, 0, 3, 0, 32'h34,       32'h0,        1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 1, 9, 4, 32'h0,        32'h0,        0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,         0, 9, 0, 9, 1, 32'h0,        32'h0,        0, 0, 1, 0));
  end

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    model_clear();
    rst = 1'b1;
    #3;
    chk("rst_cnt", 32'(pend_cnt), 32'd0);
    chk("rst_data", rs_data[31:0], 32'h0);
    chk("rst_ready", 32'(iss_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      we0 = tbl[i].we0; wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      we1 = tbl[i].we1; wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      iv = tbl[i].iv; ird = tbl[i].ird; fl = tbl[i].fl;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
      #2;
      chk($sformatf("v%0d_d0", i), rs_data[31:0], tbl[i].e_d0);
      chk($sformatf("v%0d_d1", i), rs_data[63:32], tbl[i].e_d1);
      chk($sformatf("v%0d_b0", i), 32'(rs_busy[0]), 32'(tbl[i].e_b0));
      chk($sformatf("v%0d_b1", i), 32'(rs_busy[1]), 32'(tbl[i].e_b1));
      chk($sformatf("v%0d_rdy", i), 32'(iss_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      model_update();
      #1;
      chk($sformatf("v%0d_cnt", i), 32'(pend_cnt), 32'(tbl[i].e_cnt));
    end

    // Async reset with three registers pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      iv = 1; ird = 5'(10 + i);
      we0 = 1; wa0 = 20; wd0 = 32'hAA55_0000 + 32'(i);
      model_cycle();
    end
    chk("pre_rst_cnt", 32'(pend_cnt), 32'd3);
    @(negedge clk);
    idle_inputs();
    ra0 = 20; ra1 = 10; ird = 10;
    #1;
    rst = 1'b1;
    #1;
    chk("arst_cnt", 32'(pend_cnt), 32'd0);
    chk("arst_d0", rs_data[31:0], 32'h0);
    chk("arst_busy1", 32'(rs_busy[1]), 32'd0);
    chk("arst_ready", 32'(iss_ready), 32'd1);
    // Writes and issues during reset must have no effect.
    we0 = 1; wa0 = 21; wd0 = 32'h7; iv = 1; ird = 13;
    #1;
    chk("arst_fwd_d", rs_data[31:0], 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_clear();
    ra0 = 21; ra1 = 20;
    model_cycle();
    ra0 = 13; ra1 = 10;
    model_cycle();

    // Random traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      iv  = 1'($urandom_range(0, 1)); ird = 5'($urandom_range(0, 7));
      fl  = ($urandom_range(0, 15) == 0);
      ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
      model_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
